// File: rtl/adam_aes_enc_arbiter_if.sv
// Request/response and core-side signal bundle for adam_aes_enc_arbiter.
// The slave modport is the arbiter's view; master is the requester/core side.
interface adam_aes_enc_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_block;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [127:0]        rsp_block;
  logic                rsp_err;
  logic                core_next;
  logic [127:0]        core_block;
  logic [127:0]        core_new_block;
  logic                core_ready;
  logic                busy;

  modport slave (
    input  req_valid, req_block, rsp_ready, core_new_block, core_ready,
    output req_ready, rsp_valid, rsp_block, rsp_err, core_next, core_block, busy
  );

  modport master (
    output req_valid, req_block, rsp_ready, core_new_block, core_ready,
    input  req_ready, rsp_valid, rsp_block, rsp_err, core_next, core_block, busy
  );
endinterface

// File: rtl/adam_aes_enc_arbiter.sv
// Round-robin arbiter sharing one AES encipher core among NREQ requesters.
// Optional WAIT watchdog is compiled in with `define ADAM_AES_ARB_WATCHDOG_EN.
module adam_aes_enc_arbiter #(
  parameter int NREQ        = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  adam_aes_enc_arbiter_if.slave bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  if (NREQ < 1 || NREQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
    $error("adam_aes_enc_arbiter: NREQ must be 1..8 and WDOG_CYCLES at least 1");
  end

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant_reg;
  logic [127:0]  block_reg;
  logic [127:0]  rsp_reg;
  logic          wait_armed;

  logic [GW-1:0] grant_idx;
  logic [GW-1:0] cand;
  logic          grant_found;
  logic [127:0]  sel_block;
  logic          take_grant;
  logic          core_done;
  logic          wdog_hit;
  logic          rsp_done;
  logic [GW-1:0] rr_next;

  // Search upward from rr_ptr, wrapping, for the first pending requester.
  // NOTE: every signal written in always_comb gets a default first so no path infers a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = GW'((int'(rr_ptr) + off) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_block = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == GW'(k)) sel_block = bus.req_block[k*128 +: 128];
    end
  end

  // A grant is only offered while the core is idle, so the accepted block never waits.
  assign take_grant = (state == ST_IDLE) && grant_found && bus.core_ready;

  // The core's ready flag is registered and still reads 1 in the first WAIT cycle.
  assign core_done  = (state == ST_WAIT) && wait_armed && bus.core_ready;
  assign rsp_done   = (state == ST_RESP) && bus.rsp_ready[grant_reg];
  assign rr_next    = GW'((int'(grant_reg) + 1) % NREQ);

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (take_grant)         bus.req_ready[grant_idx] = 1'b1;
    if (state == ST_RESP)   bus.rsp_valid[grant_reg] = 1'b1;
  end

  assign bus.rsp_block  = rsp_reg;
  assign bus.core_block = block_reg;
  assign bus.core_next  = (state == ST_START);
  assign bus.busy       = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_reg  <= '0;
      block_reg  <= '0;
      rsp_reg    <= '0;
      wait_armed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_grant) begin
            block_reg <= sel_block;
            grant_reg <= grant_idx;
            state     <= ST_START;
          end
        end
        ST_START: begin
          wait_armed <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_armed <= 1'b1;
          if (core_done) begin
            rsp_reg <= bus.core_new_block;
            state   <= ST_RESP;
          end else if (wdog_hit) begin
            rsp_reg <= '0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            rr_ptr <= rr_next;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADAM_AES_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_cnt;
  logic          err_reg;

  // Abort in the WDOG_CYCLES-th WAIT cycle: that cycle's increment reaches the limit.
  assign wdog_hit    = (state == ST_WAIT) && (wdog_cnt >= WW'(WDOG_CYCLES - 1));
  assign bus.rsp_err = err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (state == ST_START) begin
        wdog_cnt <= '0;
      end else if (state == ST_WAIT && wdog_cnt != '1) begin
        wdog_cnt <= wdog_cnt + WW'(1);
      end
      if (wdog_hit && !core_done) begin
        err_reg <= 1'b1;
      end else if (rsp_done) begin
        err_reg <= 1'b0;
      end
    end
  end
`else
  assign wdog_hit    = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_adam_aes_enc_arbiter.sv
// Scoreboard bench for adam_aes_enc_arbiter with a latency-modelled AES core.
// Build with ADAM_AES_ARB_WATCHDOG_EN defined to exercise the watchdog abort.
module tb_adam_aes_enc_arbiter;

  localparam int NREQ = 4;
`ifdef ADAM_AES_ARB_WATCHDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 64;
`endif

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    int           idx;
    logic [127:0] blk;
    logic         err;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  int   cyc;
  exp_t exp_q[$];

  int           core_lat;
  logic         core_stall;
  logic         core_force_low;
  logic         core_rdy_q;
  logic         core_pend;
  int           core_cnt;
  logic [127:0] core_pt;
  logic [127:0] core_res_q;

  adam_aes_enc_arbiter_if #(.NREQ(NREQ)) bus ();

  adam_aes_enc_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: the known FIPS-197 vector, otherwise a fixed scramble.
  function automatic logic [127:0] core_fn(input logic [127:0] pt);
    if (pt == FIPS_PT) return FIPS_CT;
    return {pt[95:0], pt[127:96]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  // Ready is registered: it still reads 1 the cycle after next is seen, then drops.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_rdy_q <= 1'b1;
      core_pend  <= 1'b0;
      core_cnt   <= 0;
      core_pt    <= '0;
      core_res_q <= '0;
    end else begin
      if (core_pend) begin
        core_pend  <= 1'b0;
        core_rdy_q <= 1'b0;
        core_cnt   <= core_lat;
        core_res_q <= '0;
      end else if (!core_rdy_q && !core_stall) begin
        if (core_cnt <= 1) begin
          core_rdy_q <= 1'b1;
          core_res_q <= core_fn(core_pt);
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
      if (bus.core_next) begin
        core_pend <= 1'b1;
        core_pt   <= bus.core_block;
      end
    end
  end

  assign bus.core_ready     = core_rdy_q & ~core_force_low;
  assign bus.core_new_block = core_res_q;

  // Scoreboard: push on request accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      for (int g = 0; g < NREQ; g++) begin
        if (bus.req_valid[g] && bus.req_ready[g]) begin
          exp_t e;
          e.idx = g;
          e.blk = core_stall ? 128'h0 : core_fn(bus.req_block[g*128 +: 128]);
          e.err = core_stall;
          exp_q.push_back(e);
        end
        if (bus.rsp_valid[g] && bus.rsp_ready[g]) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: response on requester %0d with nothing outstanding", g);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (g !== e.idx || bus.rsp_block !== e.blk || bus.rsp_err !== e.err) begin
              n_err++;
              $display("FAIL sb_rsp: got req=%0d blk=%h err=%b, expected req=%0d blk=%h err=%b",
                       g, bus.rsp_block, bus.rsp_err, e.idx, e.blk, e.err);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== '0) begin n_err++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err: got %b expected 0", bus.rsp_err); end
    n_cmp++; if (bus.core_next !== 1'b0) begin n_err++; $display("FAIL rst_core_next: got %b expected 0", bus.core_next); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.core_block !== 128'h0) begin n_err++; $display("FAIL rst_core_block: got %h expected 0", bus.core_block); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] acc;
    int              order[$];
    for (int r = 0; r < 2; r++) begin
      tick();
      for (int g = 0; g < NREQ; g++) bus.req_block[g*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      bus.req_valid = '1;
      bus.rsp_ready = '1;
      order.delete();
      for (int i = 0; i < 400 && order.size() < NREQ; i++) begin
        @(negedge clk);
        acc = bus.req_ready & bus.req_valid;
        if (bus.req_ready != '0) begin
          n_cmp++;
          if (!$onehot(bus.req_ready)) begin n_err++; $display("FAIL rr_onehot: got %b expected one bit", bus.req_ready); end
        end
        for (int g = 0; g < NREQ; g++) if (acc[g]) order.push_back(g);
        tick();
        bus.req_valid = bus.req_valid & ~acc;
      end
      n_cmp++;
      if (order.size() != NREQ) begin
        n_err++; $display("FAIL rr_count: got %0d grants expected %0d", order.size(), NREQ);
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          n_cmp++;
          if (order[k] != k) begin n_err++; $display("FAIL rr_order: grant %0d got requester %0d expected %0d", k, order[k], k); end
        end
      end
      for (int i = 0; i < 200 && bus.busy; i++) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: got busy=%b expected 0", bus.busy); end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_drain: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_single_fips();
    int t_acc, t_next, t_rsp, n_next;
    n_next = 0; t_next = -1; t_rsp = -1;
    tick();
    bus.req_block[0 +: 128] = FIPS_PT;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = '0;
    @(negedge clk);
    t_acc = cyc;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_accept: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.core_next) begin n_next++; t_next = cyc; end
      if (bus.rsp_valid != '0) begin t_rsp = cyc; break; end
    end
    n_cmp++; if (n_next != 1) begin n_err++; $display("FAIL single_next_count: got %0d expected 1", n_next); end
    n_cmp++; if (t_next != t_acc + 1) begin n_err++; $display("FAIL single_next_time: got %0d expected %0d", t_next, t_acc + 1); end
    n_cmp++; if (t_rsp != t_acc + 4 + core_lat) begin n_err++; $display("FAIL single_rsp_time: got %0d expected %0d", t_rsp, t_acc + 4 + core_lat); end
    n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_err++; $display("FAIL single_rsp_valid: got %b expected 0001", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_block !== FIPS_CT) begin n_err++; $display("FAIL single_rsp_block: got %h expected %h", bus.rsp_block, FIPS_CT); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL single_rsp_err: got %b expected 0", bus.rsp_err); end
    tick();
    bus.rsp_ready = 4'b0001;
    @(negedge clk);
    tick();
    bus.rsp_ready = '0;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_done: got rsp_valid=%b busy=%b expected 0/0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    int           bad;
    bad = 0;
    tick();
    bus.rsp_ready = '0;
    bus.req_block[2*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_accept2: got %b expected 0100", bus.req_ready); end
    tick();
    bus.req_block[1*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 4'b1011;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) break;
    end
    n_cmp++; if (bus.rsp_valid !== 4'b0100) begin n_err++; $display("FAIL bp_rsp_valid: got %b expected 0100", bus.rsp_valid); end
    held = bus.rsp_block;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid !== 4'b0100 || bus.rsp_block !== held || bus.req_ready !== '0) bad++;
      @(negedge clk);
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    tick();
    bus.rsp_ready = '1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL bp_early_accept: got %b expected 0000", bus.req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_accept1: got %b expected 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got busy=%b expected 0", bus.busy); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_core_not_ready();
    int bad;
    bad = 0;
    tick();
    core_force_low = 1'b1;
    bus.req_block[1*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = 4'b0010;
    bus.rsp_ready = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.req_ready !== '0 || bus.busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL cnr_no_grant: got %0d granting cycles expected 0", bad); end
    tick();
    core_force_low = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL cnr_grant: got %b expected 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL cnr_drain: got outstanding=%0d busy=%b expected 0/0", exp_q.size(), bus.busy); end
  endtask

  task automatic test_reset_mid_wait();
    tick();
    bus.rsp_ready = '0;
    bus.req_block[3*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = 4'b1000;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL rmw_accept3: got %b expected 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.core_next !== 1'b1) begin n_err++; $display("FAIL rmw_core_next: got %b expected 1", bus.core_next); end
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.core_next !== 1'b0) begin n_err++; $display("FAIL rmw_state: got busy=%b core_next=%b expected 0/0", bus.busy, bus.core_next); end
    n_cmp++; if (bus.rsp_valid !== '0 || bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL rmw_rsp: got rsp_valid=%b rsp_err=%b expected 0/0", bus.rsp_valid, bus.rsp_err); end
    n_cmp++; if (bus.req_ready !== '0 || bus.core_block !== 128'h0) begin n_err++; $display("FAIL rmw_regs: got req_ready=%b core_block=%h expected 0/0", bus.req_ready, bus.core_block); end
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    tick();
    for (int g = 0; g < NREQ; g++) bus.req_block[g*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rmw_rr_ptr: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rmw_fresh: got outstanding=%0d busy=%b expected 0/0", exp_q.size(), bus.busy); end
  endtask

  task automatic test_watchdog();
    int t_acc, t_rsp, bad;
    t_rsp = -1; bad = 0;
    tick();
    core_stall = 1'b1;
    bus.req_block[0 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = 4'b0001;
    bus.rsp_ready = '0;
    @(negedge clk);
    t_acc = cyc;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL wd_accept: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
`ifdef ADAM_AES_ARB_WATCHDOG_EN
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin t_rsp = cyc; break; end
    end
    n_cmp++; if (t_rsp != t_acc + 2 + WDOG) begin n_err++; $display("FAIL wd_time: got %0d expected %0d", t_rsp, t_acc + 2 + WDOG); end
    n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_err++; $display("FAIL wd_rsp_valid: got %b expected 0001", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_err !== 1'b1) begin n_err++; $display("FAIL wd_rsp_err: got %b expected 1", bus.rsp_err); end
    n_cmp++; if (bus.rsp_block !== 128'h0) begin n_err++; $display("FAIL wd_rsp_block: got %h expected 0", bus.rsp_block); end
    tick();
    bus.rsp_ready = 4'b0001;
    @(negedge clk);
    tick();
    bus.rsp_ready = '0;
    @(negedge clk);
    n_cmp++; if (bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL wd_clear: got rsp_err=%b busy=%b expected 0/0", bus.rsp_err, bus.busy); end
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.rsp_valid !== '0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wd_hang: got %0d cycles not waiting expected 0", bad); end
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
`endif
    core_stall = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    cyc            = 0;
    core_lat       = 3;
    core_stall     = 1'b0;
    core_force_low = 1'b0;
    reset_n        = 1'b0;
    bus.req_valid  = '0;
    bus.req_block  = '0;
    bus.rsp_ready  = '0;

    test_reset();
    test_round_robin();
    test_single_fips();
    test_backpressure();
    test_core_not_ready();
    test_reset_mid_wait();
    test_watchdog();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
